// File: rtl/full_adder_half_pkg.sv
// full_adder_half_pkg: shared width limits for the full_adder_half datapath stage
package full_adder_half_pkg;
  localparam int WIDTH_DEFAULT = 1;
  localparam int WIDTH_MAX = 64;
endpackage

// File: rtl/half_adder.sv
// half_adder: one-bit half adder
//   x, y  : addend bits
//   sum   : x ^ y
//   carry : x & y
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  assign sum = x ^ y;
  assign carry = x & y;
endmodule

// File: rtl/full_adder_half.sv
// full_adder_half: registered WIDTH-bit ripple-carry adder, each slice built from two half adders
//   clk, rst_n (async, active-low)
//   in_valid, a, b, ci : operands, sampled when in_valid is high
//   s, co, out_valid   : sum and carry-out, one cycle after capture
//   ovf                : signed overflow, present only when FULL_ADDER_HALF_OVF_EN is defined
module full_adder_half
  import full_adder_half_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid
`ifdef FULL_ADDER_HALF_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] p, g1, g2, sum;
  logic [WIDTH-1:0] s_d, s_q;
  logic co_d, co_q, out_valid_d, out_valid_q;
  assign c[0] = ci;
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    half_adder u_ha1 (.x(a[i]), .y(b[i]), .sum(p[i]), .carry(g1[i]));
    half_adder u_ha2 (.x(p[i]), .y(c[i]), .sum(sum[i]), .carry(g2[i]));
    assign c[i+1] = g1[i] | g2[i];
  end
`ifdef FULL_ADDER_HALF_OVF_EN
  logic ovf_d, ovf_q;
  assign ovf = ovf_q;
`endif
  always_comb begin
    s_d = in_valid ? sum : s_q;
    co_d = in_valid ? c[WIDTH] : co_q;
    out_valid_d = in_valid;
`ifdef FULL_ADDER_HALF_OVF_EN
    ovf_d = in_valid ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      co_q <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FULL_ADDER_HALF_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      s_q <= s_d;
      co_q <= co_d;
      out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_HALF_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign s = s_q;
  assign co = co_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder_half.sv
// tb_full_adder_half: directed checks of 1-bit and 8-bit registered adders
module tb_full_adder_half;
  logic clk, rst_n;
  logic v1, a1, b1, ci1, s1, co1, ov1;
  logic v8, ci8, co8, ov8;
  logic [7:0] a8, b8, s8;
`ifdef FULL_ADDER_HALF_OVF_EN
  logic ovf8, ovf1;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_s1, exp_c1;

  full_adder_half #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .ci(ci1),
    .s(s1), .co(co1), .out_valid(ov1)
`ifdef FULL_ADDER_HALF_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_half #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .ci(ci8),
    .s(s8), .co(co8), .out_valid(ov8)
`ifdef FULL_ADDER_HALF_OVF_EN
    , .ovf(ovf8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    check({tag, " s8"}, 64'(s8), 64'(es));
    check({tag, " co8"}, 64'(co8), 64'(ec));
    check({tag, " ov8"}, 64'(ov8), 64'(ev));
  endtask

  initial begin
    exp_s1 = 8'b1001_0110;
    exp_c1 = 8'b1110_1000;
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
    v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    #2;
    check("rst async s1", 64'(s1), 64'(0));
    check("rst async co1", 64'(co1), 64'(0));
    check("rst async ov1", 64'(ov1), 64'(0));
    check8("rst async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check8("rst held edge", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    v8 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      {a1, b1, ci1} = 3'(v);
      v1 = 1'b1;
      @(negedge clk);
      check($sformatf("w1 s abc=%0d", v), 64'(s1), 64'(exp_s1[v]));
      check($sformatf("w1 co abc=%0d", v), 64'(co1), 64'(exp_c1[v]));
      check($sformatf("w1 ov abc=%0d", v), 64'(ov1), 64'(1));
    end
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    @(negedge clk);
    check("w1 hold s", 64'(s1), 64'(1));
    check("w1 hold co", 64'(co1), 64'(1));
    check("w1 hold ov", 64'(ov1), 64'(0));
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    check8("ff+01", 8'h00, 1'b1, 1'b1);
`ifdef FULL_ADDER_HALF_OVF_EN
    check("ff+01 ovf", 64'(ovf8), 64'(0));
`endif
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    @(negedge clk);
    check8("00+00", 8'h00, 1'b0, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(negedge clk);
    check8("ff+ff+1", 8'hFF, 1'b1, 1'b1);
`ifdef FULL_ADDER_HALF_OVF_EN
    check("ff+ff+1 ovf", 64'(ovf8), 64'(0));
`endif
    v8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      @(negedge clk);
      check8($sformatf("hold %0d", k), 8'hFF, 1'b1, 1'b0);
    end
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    @(negedge clk);
    check8("12+34", 8'h46, 1'b0, 1'b1);
    a8 = 8'h55; b8 = 8'h22; ci8 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check8("midrst async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check8("midrst discard", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check8("after rst 55+22+1", 8'h78, 1'b0, 1'b1);
`ifdef FULL_ADDER_HALF_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    check8("7f+01", 8'h80, 1'b0, 1'b1);
    check("7f+01 ovf", 64'(ovf8), 64'(1));
    a8 = 8'h80; b8 = 8'hFF; ci8 = 1'b0;
    @(negedge clk);
    check8("80+ff", 8'h7F, 1'b1, 1'b1);
    check("80+ff ovf", 64'(ovf8), 64'(1));
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    check8("01+01", 8'h02, 1'b0, 1'b1);
    check("01+01 ovf", 64'(ovf8), 64'(0));
`endif
    v8 = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
